// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - binary to BCD conversion with 3-digit seven-segment scan
// Double-dabble FSM commits digits to a display register; a free-running scan multiplexes them.
module seven_seg_scan_controller #(
   parameter int REFRESH_DIV   = 4,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [6:0]  DataIn,
   input  logic        DataValid,
   output logic        Ready,
   output logic        Busy,
   output logic [11:0] BcdOut,
   output logic [6:0]  SegOut,
   output logic [2:0]  DigitEn
);

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_t        state;
   logic [6:0]    shiftReg;
   logic [11:0]   bcdAcc;
   logic [11:0]   bcdAdj;
   logic [2:0]    iterCnt;
   logic [PW-1:0] prescaler;
   logic [1:0]    scanIdx;
   logic [3:0]    curDigit;
   logic          curBlank;

   assign Ready = (state == IDLE);
   assign Busy  = ~Ready;

   // Add-3 correction applied to every nibble before each shift
   always_comb begin
      bcdAdj = bcdAcc;
      for (int i = 0; i < 3; i++) begin
         if (bcdAcc[4*i +: 4] >= 4'd5)
            bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         shiftReg <= '0;
         bcdAcc   <= '0;
         iterCnt  <= '0;
         BcdOut   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (DataValid) begin
                  shiftReg <= DataIn;
                  bcdAcc   <= '0;
                  iterCnt  <= '0;
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               {bcdAcc, shiftReg} <= {bcdAdj, shiftReg} << 1;
               iterCnt            <= iterCnt + 3'd1;
               if (iterCnt == 3'd6)
                  state <= COMMIT;
            end
            COMMIT: begin
               BcdOut <= bcdAcc;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         prescaler <= '0;
         scanIdx   <= 2'd0;
         DigitEn   <= 3'b001;
      end else if (prescaler == PW'(REFRESH_DIV - 1)) begin
         prescaler <= '0;
         if (scanIdx == 2'd2) begin
            scanIdx <= 2'd0;
            DigitEn <= 3'b001;
         end else begin
            scanIdx <= scanIdx + 2'd1;
            DigitEn <= {DigitEn[1:0], DigitEn[2]};
         end
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   function automatic logic [6:0] encodeDigit(input logic [3:0] d);
      case (d)
         4'd0:    encodeDigit = 7'h3F;
         4'd1:    encodeDigit = 7'h06;
         4'd2:    encodeDigit = 7'h5B;
         4'd3:    encodeDigit = 7'h4F;
         4'd4:    encodeDigit = 7'h66;
         4'd5:    encodeDigit = 7'h6D;
         4'd6:    encodeDigit = 7'h7D;
         4'd7:    encodeDigit = 7'h07;
         4'd8:    encodeDigit = 7'h7F;
         4'd9:    encodeDigit = 7'h6F;
         default: encodeDigit = 7'h00;
      endcase
   endfunction

   // Ones is never blanked so a zero value still shows '0'
   always_comb begin
      curDigit = BcdOut[3:0];
      curBlank = 1'b0;
      case (scanIdx)
         2'd1: begin
            curDigit = BcdOut[7:4];
            curBlank = BLANK_LEADING && (BcdOut[11:4] == 8'h00);
         end
         2'd2: begin
            curDigit = BcdOut[11:8];
            curBlank = BLANK_LEADING && (BcdOut[11:8] == 4'h0);
         end
         default: begin
            curDigit = BcdOut[3:0];
            curBlank = 1'b0;
         end
      endcase
      SegOut = curBlank ? 7'h00 : encodeDigit(curDigit);
   end

endmodule
